// File: rtl/fp_combination_mc_pkg.sv
// fp_combination_mc_pkg: shared float field widths, bias, packing offsets and round modes
package fp_combination_mc_pkg;
  typedef enum logic {RND_TRUNC = 1'b0, RND_RNE = 1'b1} rnd_mode_e;
  localparam int DEF_EXP_WIDTH = 8;
  localparam int DEF_MANTISSA_WIDTH = 7;
  function automatic int fp_width(int ew, int mw);
    return 1 + ew + mw;
  endfunction
  function automatic int fp_bias(int ew);
    return 2 ** (ew - 1) - 1;
  endfunction
  function automatic int exp_calc_width(int ew, int aw);
    return ew + $clog2(aw) + 2;
  endfunction
  function automatic int sign_pos(int ew, int mw);
    return ew + mw;
  endfunction
endpackage

// File: rtl/fp_combination_mc_if.sv
// fp_combination_mc_if: accumulator, exponent and result handshakes
interface fp_combination_mc_if
  import fp_combination_mc_pkg::*;
#(
  parameter int ACC_WIDTH = 10,
  parameter int CH_NUM = 4,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH
);
  localparam int FPW = fp_width(EXP_WIDTH, MANTISSA_WIDTH);
  logic [CH_NUM*ACC_WIDTH-1:0] acc;
  logic acc_vld, acc_rdy;
  logic [EXP_WIDTH-1:0] nmc_exp_max;
  logic nmc_exp_max_vld, nmc_exp_max_rdy;
  logic [EXP_WIDTH-1:0] data_wr_exp_max;
  logic data_wr_exp_max_vld, data_wr_exp_max_rdy;
  logic [CH_NUM*FPW-1:0] fp_result;
  logic fp_result_vld, fp_result_rdy;
  modport master (
    output acc, acc_vld, nmc_exp_max, nmc_exp_max_vld, data_wr_exp_max, data_wr_exp_max_vld, fp_result_rdy,
    input acc_rdy, nmc_exp_max_rdy, data_wr_exp_max_rdy, fp_result, fp_result_vld
  );
  modport slave (
    input acc, acc_vld, nmc_exp_max, nmc_exp_max_vld, data_wr_exp_max, data_wr_exp_max_vld, fp_result_rdy,
    output acc_rdy, nmc_exp_max_rdy, data_wr_exp_max_rdy, fp_result, fp_result_vld
  );
endinterface

// File: rtl/fp_combination_mc_norm_round.sv
// fp_norm_round: per-channel leading-one detect, normalise, round and special-case packing
module fp_norm_round
  import fp_combination_mc_pkg::*;
#(
  parameter int ACC_WIDTH = 10,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
  parameter int ROUND_EN = 1,
  localparam int EW = exp_calc_width(EXP_WIDTH, ACC_WIDTH),
  localparam int FPW = fp_width(EXP_WIDTH, MANTISSA_WIDTH),
  localparam int PW = $clog2(ACC_WIDTH)
) (
  input  logic                 sign_i,
  input  logic [ACC_WIDTH-1:0] mag_i,
  input  logic signed [EW-1:0] exp_i,
  output logic [FPW-1:0]       fp_o
);
  logic [PW-1:0] p;
  logic [ACC_WIDTH-1:0] norm;
  logic [ACC_WIDTH+MANTISSA_WIDTH:0] ext;
  logic [MANTISSA_WIDTH-1:0] mant;
  logic guard, sticky, up;
  logic [MANTISSA_WIDTH:0] mant_r;
  logic signed [EW-1:0] e;
  // ext puts the leading one at its MSB with room below for guard and sticky bits
  always_comb begin
    p = '0;
    for (int i = 0; i < ACC_WIDTH; i++) p = mag_i[i] ? PW'(i) : p;
    norm = mag_i << (PW'(ACC_WIDTH - 1) - p);
    ext = {norm, {(MANTISSA_WIDTH + 1){1'b0}}};
    mant = ext[ACC_WIDTH+MANTISSA_WIDTH-1 -: MANTISSA_WIDTH];
    guard = ext[ACC_WIDTH-1];
    sticky = |ext[ACC_WIDTH-2:0];
    up = (ROUND_EN == int'(RND_RNE)) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + (MANTISSA_WIDTH + 1)'(up);
    e = exp_i + signed'(EW'(p)) + signed'(EW'(mant_r[MANTISSA_WIDTH]));
    fp_o = ~|mag_i ? '0 :
           e <= 0 ? {sign_i, {(FPW - 1){1'b0}}} :
           e >= 2 ** EXP_WIDTH - 1 ? {sign_i, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}} :
           {sign_i, e[EXP_WIDTH-1:0], mant_r[MANTISSA_WIDTH-1:0]};
  end
endmodule

// File: rtl/fp_combination_mc.sv
// fp_combination_mc: two-stage conversion of signed channel accumulators to packed floats
module fp_combination_mc
  import fp_combination_mc_pkg::*;
#(
  parameter int ACC_WIDTH = 10,
  parameter int CH_NUM = 4,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
  parameter int EXP_ADJ = 0,
  parameter int ROUND_EN = 1
) (
  input logic clk,
  input logic rst,
  fp_combination_mc_if.slave bus_if
);
  localparam int EW = exp_calc_width(EXP_WIDTH, ACC_WIDTH);
  localparam int FPW = fp_width(EXP_WIDTH, MANTISSA_WIDTH);
  localparam int BIAS = fp_bias(EXP_WIDTH);
  logic [EXP_WIDTH-1:0] nmc_q, wr_q, nmc_eff, wr_eff;
  logic s1_vld_q, fp_vld_q, s2_adv, acc_rdy;
  logic [CH_NUM-1:0] s1_sign_d, s1_sign_q;
  logic [CH_NUM-1:0][ACC_WIDTH-1:0] s1_mag_d, s1_mag_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q;
  logic [CH_NUM*FPW-1:0] fp_d, fp_q;
  // exponent updates arriving with a beat are bypassed so that beat sees them
  assign nmc_eff = bus_if.nmc_exp_max_vld ? bus_if.nmc_exp_max : nmc_q;
  assign wr_eff = bus_if.data_wr_exp_max_vld ? bus_if.data_wr_exp_max : wr_q;
  assign s2_adv = ~fp_vld_q | bus_if.fp_result_rdy;
  assign acc_rdy = ~s1_vld_q | s2_adv;
  assign bus_if.acc_rdy = acc_rdy;
  assign bus_if.nmc_exp_max_rdy = 1'b1;
  assign bus_if.data_wr_exp_max_rdy = 1'b1;
  assign bus_if.fp_result = fp_q;
  assign bus_if.fp_result_vld = fp_vld_q;
  always_comb begin
    s1_sign_d = '0;
    s1_mag_d = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      s1_sign_d[c] = bus_if.acc[c*ACC_WIDTH+ACC_WIDTH-1];
      s1_mag_d[c] = s1_sign_d[c] ? -bus_if.acc[c*ACC_WIDTH +: ACC_WIDTH] : bus_if.acc[c*ACC_WIDTH +: ACC_WIDTH];
    end
    s1_exp_d = EW'(wr_eff) + EW'(nmc_eff) - EW'(BIAS) + EW'(EXP_ADJ);
  end
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    fp_norm_round #(
      .ACC_WIDTH(ACC_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH), .ROUND_EN(ROUND_EN)
    ) u_norm (
      .sign_i(s1_sign_q[c]), .mag_i(s1_mag_q[c]), .exp_i(s1_exp_q), .fp_o(fp_d[c*FPW +: FPW])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      nmc_q <= '0;
      wr_q <= '0;
      s1_vld_q <= 1'b0;
      s1_sign_q <= '0;
      s1_mag_q <= '0;
      s1_exp_q <= '0;
      fp_q <= '0;
      fp_vld_q <= 1'b0;
    end else begin
      if (bus_if.nmc_exp_max_vld) nmc_q <= bus_if.nmc_exp_max;
      if (bus_if.data_wr_exp_max_vld) wr_q <= bus_if.data_wr_exp_max;
      if (acc_rdy) s1_vld_q <= bus_if.acc_vld;
      if (acc_rdy && bus_if.acc_vld) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q <= s1_mag_d;
        s1_exp_q <= s1_exp_d;
      end
      if (s2_adv) fp_vld_q <= s1_vld_q;
      if (s2_adv && s1_vld_q) fp_q <= fp_d;
    end
  end
endmodule

// File: tb/tb_fp_combination_mc.sv
// tb_fp_combination_mc: directed vectors with hand-computed float encodings
module tb_fp_combination_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic stall_q = 1'b0;
  logic [63:0] hold_q = '0;
  logic [63:0] got[$];
  logic saw_drop, acc_done;
  logic [15:0] exp_f [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};

  fp_combination_mc_if bus ();
  fp_combination_mc dut (.clk(clk), .rst(rst), .bus_if(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pk_acc(int a0, int a1, int a2, int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [63:0] pk_fp(logic [15:0] f0, logic [15:0] f1, logic [15:0] f2, logic [15:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  task automatic set_exps(logic [7:0] nmc, logic [7:0] wr);
    bus.nmc_exp_max = nmc;
    bus.data_wr_exp_max = wr;
    bus.nmc_exp_max_vld = 1'b1;
    bus.data_wr_exp_max_vld = 1'b1;
    tick();
    bus.nmc_exp_max_vld = 1'b0;
    bus.data_wr_exp_max_vld = 1'b0;
  endtask

  task automatic beat(string tag, logic [39:0] a, logic [63:0] exp);
    bus.acc = a;
    bus.acc_vld = 1'b1;
    tick();
    bus.acc_vld = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.fp_result_vld), 64'd0);
    tick();
    chk({tag, "_vld"}, 64'(bus.fp_result_vld), 64'd1);
    chk(tag, bus.fp_result, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_q) begin
        chk("hold_vld", 64'(bus.fp_result_vld), 64'd1);
        chk("hold_data", bus.fp_result, hold_q);
      end
      if (bus.fp_result_vld && bus.fp_result_rdy) got.push_back(bus.fp_result);
      stall_q <= bus.fp_result_vld && !bus.fp_result_rdy;
      hold_q <= bus.fp_result;
    end
  end

  initial begin
    bus.acc = '0;
    bus.acc_vld = 1'b0;
    bus.nmc_exp_max = '0;
    bus.nmc_exp_max_vld = 1'b0;
    bus.data_wr_exp_max = '0;
    bus.data_wr_exp_max_vld = 1'b0;
    bus.fp_result_rdy = 1'b1;
    repeat (2) tick();
    chk("rst_vld", 64'(bus.fp_result_vld), 64'd0);
    chk("rst_res", bus.fp_result, 64'd0);
    rst = 1'b0;
    chk("rst_acc_rdy", 64'(bus.acc_rdy), 64'd1);
    chk("nmc_rdy", 64'(bus.nmc_exp_max_rdy), 64'd1);
    chk("wr_rdy", 64'(bus.data_wr_exp_max_rdy), 64'd1);

    set_exps(8'd127, 8'd127);
    beat("basic", pk_acc(1, -3, 511, 257), pk_fp(16'h3F80, 16'hC040, 16'h4400, 16'h4380));
    tick();
    chk("vld_drop", 64'(bus.fp_result_vld), 64'd0);
    beat("edges", pk_acc(0, -512, -1, 2), pk_fp(16'h0000, 16'hC400, 16'hBF80, 16'h4000));

    set_exps(8'd0, 8'd0);
    beat("flush", pk_acc(1, -1, 511, 0), pk_fp(16'h0000, 16'h8000, 16'h0000, 16'h0000));
    set_exps(8'd255, 8'd255);
    beat("inf", pk_acc(-1, 1, 0, 0), pk_fp(16'hFF80, 16'h7F80, 16'h0000, 16'h0000));

    set_exps(8'd127, 8'd127);
    bus.nmc_exp_max = 8'd128;
    bus.nmc_exp_max_vld = 1'b1;
    beat("bypass", pk_acc(1, 0, 0, 0), pk_fp(16'h4000, 16'h0000, 16'h0000, 16'h0000));
    bus.nmc_exp_max_vld = 1'b0;
    beat("nmc_held", pk_acc(1, 0, 0, 0), pk_fp(16'h4000, 16'h0000, 16'h0000, 16'h0000));

    set_exps(8'd127, 8'd127);
    tick();
    got.delete();
    saw_drop = 1'b0;
    bus.fp_result_rdy = 1'b0;
    mon_en = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          bus.acc = pk_acc(i, -i, 0, 0);
          bus.acc_vld = 1'b1;
          acc_done = 1'b0;
          for (int w = 0; w < 20 && !acc_done; w++) begin
            @(negedge clk);
            if (bus.acc_rdy) acc_done = 1'b1;
            else saw_drop = 1'b1;
            tick();
          end
        end
        bus.acc_vld = 1'b0;
      end
      begin
        for (int w = 0; w < 20 && !bus.fp_result_vld; w++) tick();
        repeat (3) tick();
        bus.fp_result_rdy = 1'b1;
      end
    join
    for (int w = 0; w < 30 && got.size() < 5; w++) tick();
    mon_en = 1'b0;
    chk("acc_rdy_drop", 64'(saw_drop), 64'd1);
    chk("stream_cnt", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("stream%0d", i), i < got.size() ? got[i] : 64'hX, pk_fp(exp_f[i], exp_f[i] | 16'h8000, 16'h0, 16'h0));

    bus.acc = pk_acc(1, 0, 0, 0);
    bus.acc_vld = 1'b1;
    tick();
    bus.acc = pk_acc(2, 0, 0, 0);
    rst = 1'b1;
    tick();
    bus.acc_vld = 1'b0;
    chk("mid_rst_vld", 64'(bus.fp_result_vld), 64'd0);
    chk("mid_rst_res", bus.fp_result, 64'd0);
    rst = 1'b0;
    chk("post_rst_acc_rdy", 64'(bus.acc_rdy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("no_stale%0d", i), 64'(bus.fp_result_vld), 64'd0);
    end
    beat("rst_exps", pk_acc(1, 0, 0, 0), pk_fp(16'h0000, 16'h0000, 16'h0000, 16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
